// File: rtl/program_loader.sv
// Byte-serial host loader for the cpu: bulk write/readback of the external
// instruction and data memory ports, plus run/halt control of cpu_enable.
module program_loader #(
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        cpu_enable,
  output logic        busy,
  output logic        error,
  output logic [31:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [31:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [31:0] wdata_ext_2,
  input  logic [31:0] rdata_ext_2
);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_WR_BYTE, S_WR_WORD, S_RD_REQ, S_RD_WAIT, S_RD_SEND
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] word_q, word_d;
  logic        dmem_q, dmem_d;
  logic        rd_q, rd_d;
  logic        supp_q, supp_d;   // out-of-bounds write: drain bytes, no strobes
  logic        cpu_en_q, cpu_en_d;
  logic        err_q, err_d;

  logic        in_fire, out_fire, last_word, wr_act, rd_act;
  logic [15:0] n_full, idx_inc;
  logic [16:0] depth;
  logic [31:0] mem_addr;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      bcnt_q   <= '0;
      word_q   <= '0;
      dmem_q   <= 1'b0;
      rd_q     <= 1'b0;
      supp_q   <= 1'b0;
      cpu_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      word_q   <= word_d;
      dmem_q   <= dmem_d;
      rd_q     <= rd_d;
      supp_q   <= supp_d;
      cpu_en_q <= cpu_en_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) || (state_q == S_CNT_HI) ||
                (state_q == S_CNT_LO) || (state_q == S_WR_BYTE);
    in_fire   = in_valid && in_ready;
    out_valid = (state_q == S_RD_SEND);
    out_fire  = out_valid && out_ready;
    // CNT_HI parks the high count byte in cnt_q[7:0]
    n_full    = {cnt_q[7:0], in_data};
    depth     = dmem_q ? 17'(DMEM_DEPTH) : 17'(IMEM_DEPTH);
    idx_inc   = idx_q + 16'd1;
    last_word = (idx_inc == cnt_q);
    case (bcnt_q)
      2'd0:    out_data = word_q[31:24];
      2'd1:    out_data = word_q[23:16];
      2'd2:    out_data = word_q[15:8];
      default: out_data = word_q[7:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    word_d   = word_q;
    dmem_d   = dmem_q;
    rd_d     = rd_q;
    supp_d   = supp_q;
    cpu_en_d = cpu_en_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          case (in_data)
            8'h01, 8'h02, 8'h03, 8'h04: begin
              if (cpu_en_q) begin
                err_d = 1'b1;
              end else begin
                state_d = S_CNT_HI;
                dmem_d  = (in_data == 8'h02) || (in_data == 8'h04);
                rd_d    = (in_data == 8'h03) || (in_data == 8'h04);
              end
            end
            8'h10:   cpu_en_d = 1'b1;
            8'h11:   cpu_en_d = 1'b0;
            8'h20:   err_d    = 1'b0;
            default: err_d    = 1'b1;
          endcase
        end
      end
      S_CNT_HI: begin
        if (in_fire) begin
          cnt_d   = {8'h00, in_data};
          state_d = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (in_fire) begin
          cnt_d  = n_full;
          idx_d  = '0;
          bcnt_d = '0;
          supp_d = 1'b0;
          if (n_full == 16'd0) begin
            state_d = S_IDLE;
          end else if ({1'b0, n_full} > depth) begin
            err_d = 1'b1;
            if (rd_q) begin
              state_d = S_IDLE;
            end else begin
              supp_d  = 1'b1;
              state_d = S_WR_BYTE;
            end
          end else begin
            state_d = rd_q ? S_RD_REQ : S_WR_BYTE;
          end
        end
      end
      S_WR_BYTE: begin
        if (in_fire) begin
          word_d = {word_q[23:0], in_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = S_WR_WORD;
        end
      end
      S_WR_WORD: begin
        idx_d   = idx_inc;
        state_d = last_word ? S_IDLE : S_WR_BYTE;
      end
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        word_d  = dmem_q ? rdata_ext_2 : rdata_ext;
        bcnt_d  = '0;
        state_d = S_RD_SEND;
      end
      S_RD_SEND: begin
        if (out_fire) begin
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            idx_d   = idx_inc;
            state_d = last_word ? S_IDLE : S_RD_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory strobes come straight from state so a reset drops them at once.
  always_comb begin
    wr_act      = (state_q == S_WR_WORD) && !supp_q;
    rd_act      = (state_q == S_RD_REQ);
    mem_addr    = {14'd0, idx_q, 2'b00};
    wen_ext     = wr_act && !dmem_q;
    wen_ext_2   = wr_act && dmem_q;
    ren_ext     = rd_act && !dmem_q;
    ren_ext_2   = rd_act && dmem_q;
    addr_ext    = (wen_ext || ren_ext) ? mem_addr : '0;
    addr_ext_2  = (wen_ext_2 || ren_ext_2) ? mem_addr : '0;
    wdata_ext   = wen_ext ? word_q : '0;
    wdata_ext_2 = wen_ext_2 ? word_q : '0;
    cpu_enable  = cpu_en_q;
    error       = err_q;
    busy        = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: command-level model with expected write,
// read-address and readback-byte queues, checked by one negedge compare process.
module tb_program_loader;
  localparam int IMEM_DEPTH = 512;
  localparam int DMEM_DEPTH = 1024;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b1;
  logic        cpu_enable, busy, error;
  logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
  logic [31:0] rdata_ext = '0, rdata_ext_2 = '0;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;

  program_loader #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
    .clk(clk), .arst_n(arst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .cpu_enable(cpu_enable), .busy(busy), .error(error),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
  );

  always #5 clk = ~clk;

  // Memories attached to the DUT, 1-cycle read latency
  logic [31:0] dev_imem [0:IMEM_DEPTH-1];
  logic [31:0] dev_dmem [0:DMEM_DEPTH-1];
  always @(posedge clk) begin
    if (wen_ext)   dev_imem[addr_ext[10:2]]   <= wdata_ext;
    if (ren_ext)   rdata_ext                  <= dev_imem[addr_ext[10:2]];
    if (wen_ext_2) dev_dmem[addr_ext_2[11:2]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2                <= dev_dmem[addr_ext_2[11:2]];
  end

  // Model state
  logic [31:0] ref_imem [0:IMEM_DEPTH-1];
  logic [31:0] ref_dmem [0:DMEM_DEPTH-1];
  bit          exp_cpu = 0, exp_err = 0, toggle = 0;
  logic [31:0] exp_wa_i[$], exp_wd_i[$], exp_wa_d[$], exp_wd_d[$];
  logic [31:0] exp_ra_i[$], exp_ra_d[$];
  logic [7:0]  exp_out[$], cap[$];
  int          chk_n = 0, err_n = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    chk_n++;
    if (act !== want) begin
      err_n++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, want, $time);
    end
  endtask

  initial forever begin
    @(posedge clk); #2;
    out_ready = toggle ? ~out_ready : 1'b1;
  end

  // Compare process
  bit         prev_stall = 0;
  logic [7:0] prev_data = '0;
  initial forever begin
    @(negedge clk);
    if (arst_n) begin
      check("cpu_enable", 32'(cpu_enable), 32'(exp_cpu));
      check("error", 32'(error), 32'(exp_err));
      if (wen_ext || wen_ext_2 || ren_ext || ren_ext_2)
        check("strobe_excl", 32'(wen_ext) + 32'(wen_ext_2) + 32'(ren_ext) + 32'(ren_ext_2), 1);
      if (wen_ext) begin
        if (exp_wa_i.size() == 0) check("imem_wr_unexpected", 1, 0);
        else begin
          check("imem_wr_addr", addr_ext, exp_wa_i.pop_front());
          check("imem_wr_data", wdata_ext, exp_wd_i.pop_front());
        end
      end
      if (wen_ext_2) begin
        if (exp_wa_d.size() == 0) check("dmem_wr_unexpected", 1, 0);
        else begin
          check("dmem_wr_addr", addr_ext_2, exp_wa_d.pop_front());
          check("dmem_wr_data", wdata_ext_2, exp_wd_d.pop_front());
        end
      end
      if (ren_ext) begin
        if (exp_ra_i.size() == 0) check("imem_rd_unexpected", 1, 0);
        else check("imem_rd_addr", addr_ext, exp_ra_i.pop_front());
      end
      if (ren_ext_2) begin
        if (exp_ra_d.size() == 0) check("dmem_rd_unexpected", 1, 0);
        else check("dmem_rd_addr", addr_ext_2, exp_ra_d.pop_front());
      end
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        cap.push_back(out_data);
        if (exp_out.size() == 0) check("out_unexpected", 1, 0);
        else check("out_byte", 32'(out_data), 32'(exp_out.pop_front()));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic send_raw(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 500) begin @(negedge clk); t++; end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_op(input logic [7:0] b, output bit hdr);
    hdr = 0;
    send_raw(b);
    case (b)
      8'h01, 8'h02, 8'h03, 8'h04: if (exp_cpu) exp_err = 1; else hdr = 1;
      8'h10: exp_cpu = 1;
      8'h11: exp_cpu = 0;
      8'h20: exp_err = 0;
      default: exp_err = 1;
    endcase
  endtask

  task automatic wr_cmd(input logic [7:0] op, input logic [15:0] n, input logic [31:0] w[$]);
    bit hdr, ok, dm;
    logic [31:0] d;
    do_op(op, hdr);
    if (!hdr) return;
    dm = (op == 8'h02);
    ok = int'(n) <= (dm ? DMEM_DEPTH : IMEM_DEPTH);
    send_raw(n[15:8]);
    send_raw(n[7:0]);
    if (!ok) exp_err = 1;
    for (int i = 0; i < int'(n); i++) begin
      d = (i < w.size()) ? w[i] : 32'(i * 7);
      if (ok && dm) begin
        exp_wa_d.push_back(32'(i * 4)); exp_wd_d.push_back(d); ref_dmem[i] = d;
      end else if (ok) begin
        exp_wa_i.push_back(32'(i * 4)); exp_wd_i.push_back(d); ref_imem[i] = d;
      end
      for (int k = 3; k >= 0; k--) send_raw(d[k*8 +: 8]);
    end
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    @(negedge clk);
    while (busy && t < 3000) begin @(negedge clk); t++; end
    check({nm, "_idle"}, 32'(busy), 0);
    check({nm, "_queues_empty"}, 32'(exp_wa_i.size() + exp_wa_d.size() +
          exp_ra_i.size() + exp_ra_d.size() + exp_out.size()), 0);
  endtask

  task automatic rd_cmd(input logic [7:0] op, input logic [15:0] n, input bit tog);
    bit hdr, ok, dm;
    logic [31:0] d;
    do_op(op, hdr);
    if (!hdr) return;
    dm = (op == 8'h04);
    ok = int'(n) <= (dm ? DMEM_DEPTH : IMEM_DEPTH);
    send_raw(n[15:8]);
    if (ok) begin
      for (int i = 0; i < int'(n); i++) begin
        d = dm ? ref_dmem[i] : ref_imem[i];
        if (dm) exp_ra_d.push_back(32'(i * 4)); else exp_ra_i.push_back(32'(i * 4));
        for (int k = 3; k >= 0; k--) exp_out.push_back(d[k*8 +: 8]);
      end
    end
    cap.delete();
    toggle = tog;
    send_raw(n[7:0]);
    if (!ok) exp_err = 1;
    wait_idle("rd");
    toggle = 0;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_outs"}, 32'({cpu_enable, error, out_valid, busy, wen_ext, ren_ext,
          wen_ext_2, ren_ext_2}), 0);
    check({nm, "_addr"}, addr_ext | addr_ext_2, 0);
    check({nm, "_wdata"}, wdata_ext | wdata_ext_2, 0);
  endtask

  initial begin
    logic [31:0] wq[$];
    bit hdr;
    for (int i = 0; i < IMEM_DEPTH; i++) ref_imem[i] = '0;
    for (int i = 0; i < DMEM_DEPTH; i++) ref_dmem[i] = '0;

    #12;
    check_all_zero("reset");
    check("reset_in_ready", 32'(in_ready), 1);
    @(negedge clk); arst_n = 1'b1;

    // Two-word imem write
    wq.delete(); wq.push_back(32'hDEADBEEF); wq.push_back(32'h01234567);
    wr_cmd(8'h01, 16'd2, wq);
    wait_idle("wr_imem");
    check("imem0_lit", dev_imem[0], 32'hDEADBEEF);
    check("imem1_lit", dev_imem[1], 32'h01234567);

    rd_cmd(8'h03, 16'd2, 1'b0);

    // dmem preload of word 3, then readback with stalling consumer
    wq.delete(); wq.push_back(32'h0); wq.push_back(32'h0); wq.push_back(32'h0);
    wq.push_back(32'hCAFEF00D);
    wr_cmd(8'h02, 16'd4, wq);
    wait_idle("wr_dmem");
    rd_cmd(8'h04, 16'd4, 1'b1);
    check("rd_dmem_count", 32'(cap.size()), 16);
    if (cap.size() == 16) begin
      check("rd_dmem_b0", 32'(cap[0]), 0);
      check("rd_dmem_b12", 32'(cap[12]), 32'hCA);
      check("rd_dmem_b13", 32'(cap[13]), 32'hFE);
      check("rd_dmem_b14", 32'(cap[14]), 32'hF0);
      check("rd_dmem_b15", 32'(cap[15]), 32'h0D);
    end

    // Commands while running are rejected
    do_op(8'h10, hdr); do_op(8'h01, hdr); do_op(8'h00, hdr); do_op(8'h01, hdr);
    @(negedge clk);
    check("run_cpu_lit", 32'(cpu_enable), 1);
    check("run_err_lit", 32'(error), 1);
    do_op(8'h11, hdr); do_op(8'h20, hdr);
    @(negedge clk);
    check("halt_cpu_lit", 32'(cpu_enable), 0);
    check("clr_err_lit", 32'(error), 0);

    // Out-of-bounds dmem write: 1025 words drained, no strobes
    wq.delete();
    wr_cmd(8'h02, 16'd1025, wq);
    wait_idle("oob_wr");
    check("oob_err_lit", 32'(error), 1);
    do_op(8'h20, hdr);
    @(negedge clk);
    check("oob_next_op", 32'(error), 0);

    // Out-of-bounds read: no output
    rd_cmd(8'h03, 16'd513, 1'b0);
    check("oob_rd_none", 32'(cap.size()), 0);
    do_op(8'h20, hdr);

    // Zero count, then an illegal opcode
    wq.delete();
    wr_cmd(8'h01, 16'd0, wq);
    @(negedge clk);
    check("zero_busy", 32'(busy), 0);
    do_op(8'h7F, hdr);
    @(negedge clk);
    check("bad_op_err_lit", 32'(error), 1);
    do_op(8'h20, hdr);

    // Reset mid-word
    do_op(8'h01, hdr);
    send_raw(8'h00); send_raw(8'h01); send_raw(8'hAA); send_raw(8'hBB);
    @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    arst_n = 1'b0;
    exp_err = 0; exp_cpu = 0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk); arst_n = 1'b1;
    wq.delete(); wq.push_back(32'h11223344);
    wr_cmd(8'h01, 16'd1, wq);
    wait_idle("post_reset");
    check("post_reset_lit", dev_imem[0], 32'h11223344);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", chk_n, err_n);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
